dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Load/store initiator that drives the word-wide data_memory port (MemWrite, MemRead, Address, writeData, readData) on behalf of the CPU datapath.
- Accepts one byte, halfword or word load/store request at a time.
- Word-aligns the memory address, performs read-modify-write for sub-word stores, and extracts and extends sub-word load data.
- Returns one response per accepted request. Sits between the execute/memory pipeline stage and data_memory.

Parameters:
- RD_LAT, 1, cycles from MemRead+Address asserted until readData is valid (0 = combinational read).
- ADDR_W, 32, request/memory address width.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept (high only in IDLE)
- req_write  input  1  1=store, 0=load
- req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data (low bits used for b/h)
- rsp_valid  output  1  one-cycle response strobe, no backpressure
- rsp_rdata  output  32  load result (0 for stores/errors)
- rsp_err  output  1  misaligned or illegal funct3
- MemWrite  output  1  data_memory write enable
- MemRead  output  1  data_memory read enable
- Address  output  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
- writeData  output  32  word to write
- readData  input  32  word from memory

Behaviour:
- Reset (synchronous): state=IDLE; req_ready, rsp_valid, rsp_err, MemWrite, MemRead = 0; rsp_rdata, Address, writeData = 0. req_ready rises in the first cycle after reset deasserts.
- Handshake: a request is accepted on a rising edge with req_valid&&req_ready. All request fields are latched at acceptance and held internally. req_ready stays 0 until the state returns to IDLE.
- Outputs are Moore: decoded from registered state and latched fields only.
- Error check at accept:
  - h/hu with addr[0]=1 -> err.
  - w with addr[1:0]!=0 -> err.
  - funct3 011/110/111 -> err.
  - Store with funct3 100/101 -> err.
  - On err: next state RESP with rsp_err=1 and rsp_rdata=0; no memory access.
- States:
  - IDLE: req_ready=1. On accept go to RESP (err), RD_WAIT (load), WR (sw), or RMW_WAIT (sb/sh).
  - RD_WAIT: MemRead=1, Address held for RD_LAT+1 cycles. readData is captured on the edge ending the last cycle, extracted, then go to RESP.
  - RMW_WAIT: same timing as RD_WAIT. At the end, capture readData, merge in the store byte/half, then go to WR.
  - WR: MemWrite=1 for exactly one cycle, writeData = merged word (or req_wdata for sw), then go to RESP.
  - RESP: rsp_valid=1 for one cycle, then go to IDLE. rsp_rdata/rsp_err are valid only while rsp_valid=1.
- MemRead and MemWrite are never high together. Address is constant while either is high.
- Lane selection is little-endian: byte k = bits[8k+7:8k] where k=addr[1:0]; half = bits[16*addr[1]+15 : 16*addr[1]].
- Load extension: b/h sign-extend to 32; bu/hu zero-extend; w passes through.
- Latency from accept edge T, with RD_LAT=1:
  - load: rsp_valid at T+3.
  - sw: rsp_valid at T+2.
  - sb/sh: rsp_valid at T+4.
  - err: rsp_valid at T+1.
- Reset mid-operation: return to IDLE. The pending op is dropped, no rsp_valid is issued, and a not-yet-issued MemWrite never occurs.
- req_valid during a busy period is ignored; the requester must hold the request until req_ready.

Test Plan:
- sw addr 0x20 wdata 0xCAFEBABE -> T+1: MemWrite=1 for one cycle, Address=0x20, writeData=0xCAFEBABE; T+2: rsp_valid=1, rsp_err=0.
- Word 0x10=0xDEADBEEF:
  - lb 0x13 -> rsp_rdata 0xFFFFFFDE at T+3.
  - lbu 0x13 -> 0x000000DE.
  - lh 0x12 -> 0xFFFFDEAD.
  - lhu 0x10 -> 0x0000BEEF.
  - Address=0x10 and MemRead=1 during T+1..T+2 in each case.
- sb 0x11 wdata 0x000000AA over 0xDEADBEEF -> MemRead T+1..T+2, MemWrite at T+3 with writeData 0xDEADAAEF, rsp at T+4. A following lw 0x10 returns 0xDEADAAEF.
- lw 0x22, sh 0x21, and load funct3 011 -> rsp_valid at T+1, rsp_err=1, rsp_rdata=0; MemRead/MemWrite never asserted.
- reset pulsed one cycle during RMW_WAIT of sh 0x10 -> no MemWrite, no rsp_valid, req_ready=1 the cycle after reset drops; lw 0x10 still returns 0xDEADBEEF.
- Two requests back-to-back with req_valid held high -> req_ready low from T+1 through RESP; second accepted only in the following IDLE cycle; exactly two rsp_valid pulses, in order.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for the word-wide data_memory port: aligns addresses,
// does read-modify-write for sub-word stores and extends sub-word load data.
module dmem_access_ctrl #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       writeData,
    input  logic [31:0]       readData
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_WAIT  = 3'd1;
    localparam logic [2:0] S_RMW_WAIT = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    localparam int CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    logic [2:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        accept;
    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign accept = req_valid && ready_q;

    // Illegal encodings, unsigned stores, and misaligned halfword/word accesses.
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: req_err = 1'b1;
            3'b100:                 req_err = req_write;
            3'b101:                 req_err = req_write || req_addr[0];
            3'b001:                 req_err = req_addr[0];
            3'b010:                 req_err = (req_addr[1:0] != 2'b00);
            default:                req_err = 1'b0;
        endcase
    end

    // Halfword accesses are aligned here, so one byte-granular shift serves both sizes.
    assign shamt    = {addr_q[1:0], 3'b000};
    assign rd_shift = readData >> shamt;

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'h0, rd_shift[7:0]};
            3'b101:  load_ext = {16'h0, rd_shift[15:0]};
            default: load_ext = readData;
        endcase
    end

    assign lane_mask = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    assign merged    = (readData & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = '0;
                    rdata_d  = 32'h0;
                    err_d    = req_err;
                    if (req_err)                 state_d = S_RESP;
                    else if (!req_write)         state_d = S_RD_WAIT;
                    else if (req_funct3 == 3'b010) state_d = S_WR;
                    else                         state_d = S_RMW_WAIT;
                end
            end
            S_RD_WAIT, S_RMW_WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    if (state_q == S_RD_WAIT) begin
                        rdata_d = load_ext;
                        state_d = S_RESP;
                    end else begin
                        wdata_d = merged;
                        state_d = S_WR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Registered so that ready stays low while reset is held.
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign MemRead   = (state_q == S_RD_WAIT) || (state_q == S_RMW_WAIT);
    assign MemWrite  = (state_q == S_WR) && write_q;
    assign Address   = {addr_q[ADDR_W-1:2], 2'b00};
    assign writeData = wdata_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
